ssp_rx_param: RTL and testbench

Parametrised next-generation SSP receive interface running entirely in the clk_i domain.
- Oversamples the serial pins sspclkin, sspfssin and ssprxd.
- Deserialises frames of DATA_W bits and buffers them in a DEPTH-entry show-ahead FIFO.
- Adds overrun detection, FIFO fill level and selectable bit order.
- Sits between the external SSP serial pins and the host register interface.

---
 rtl/ssp_pkg.sv | 17 +
 rtl/ssp_sync_fifo.sv | 54 +++++
 rtl/ssp_rx_param.sv | 161 ++++++++++++++++
 tb/tb_ssp_rx_param.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssp_pkg.sv
// Shared types and helpers for the SSP receive path (and the planned transmit path).
package ssp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ssp_state_e;

    localparam bit BIT_ORDER_MSB = 1'b1;
    localparam bit BIT_ORDER_LSB = 1'b0;

    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ssp_sync_fifo.sv
// Show-ahead synchronous FIFO with fill level; a write into a full FIFO succeeds
// only when a read frees a slot in the same cycle, otherwise it is dropped.
module ssp_sync_fifo
    import ssp_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      wr_en,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      rd_en,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      empty,
    output logic                      full,
    output logic [level_w(DEPTH)-1:0] level,
    output logic                      wr_drop
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEVEL_W = level_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W:0]    wr_ptr_q;
    logic [PTR_W:0]    rd_ptr_q;
    logic              do_rd;
    logic              do_wr;

    // Pointers carry one extra MSB so full and empty are distinguishable.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign wr_drop = wr_en & full & ~do_rd;
    assign level   = LEVEL_W'(wr_ptr_q - rd_ptr_q);
    assign rd_data = empty ? '0 : mem[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem[wr_ptr_q[PTR_W-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ssp_rx_param.sv
// SSP receiver: oversampled serial pins, frame deserialiser and receive FIFO.
// Optional even-parity bit per frame enabled with `define SSP_RX_PARITY_EN.
module ssp_rx_param
    import ssp_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      do_read,
    input  logic                      ovr_clr,
    output logic [DATA_W-1:0]         rx_d,
    output logic                      rx_empty,
    output logic                      rx_full,
    output logic [level_w(DEPTH)-1:0] rx_level,
    output logic                      overrun,
    output logic                      parity_err,
    input  logic                      sspclkin,
    input  logic                      sspfssin,
    input  logic                      ssprxd
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] fss_sync_q;
    logic [SYNC_STAGES-1:0] rxd_sync_q;
    logic                   clk_prev_q;
    logic                   sample;
    logic                   fss;
    logic                   rxd;

    ssp_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              frame_done;
    logic [DATA_W-1:0] wr_data;
    logic              wr_drop;
`ifdef SSP_RX_PARITY_EN
    logic              par_bad;
`endif

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
        if (MSB_FIRST == BIT_ORDER_MSB) return {w[DATA_W-2:0], b};
        else                            return {b, w[DATA_W-1:1]};
    endfunction

    // Pin synchronisers and sspclkin rising-edge detect.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_sync_q <= '0;
            fss_sync_q <= '0;
            rxd_sync_q <= '0;
            clk_prev_q <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], sspclkin};
            fss_sync_q <= {fss_sync_q[SYNC_STAGES-2:0], sspfssin};
            rxd_sync_q <= {rxd_sync_q[SYNC_STAGES-2:0], ssprxd};
            clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign sample = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
    assign fss    = fss_sync_q[SYNC_STAGES-1];
    assign rxd    = rxd_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        frame_done = 1'b0;
        wr_data    = shreg_q;
`ifdef SSP_RX_PARITY_EN
        par_bad    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (sample && fss) begin
                    state_d = SHIFT;
                    cnt_d   = CNT_W'(DATA_W);
                end
            end
            SHIFT: begin
                if (sample) begin
                    shreg_d = shift_in(shreg_q, rxd);
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
`ifdef SSP_RX_PARITY_EN
                        state_d = PARITY;
`else
                        // Last bit goes straight to the FIFO in the same cycle.
                        state_d    = IDLE;
                        frame_done = 1'b1;
                        wr_data    = shreg_d;
`endif
                    end
                end
            end
`ifdef SSP_RX_PARITY_EN
            PARITY: begin
                if (sample) begin
                    state_d = IDLE;
                    // Even parity: data bits plus parity bit must XOR to zero.
                    if ((^shreg_q) ^ rxd) par_bad    = 1'b1;
                    else                  frame_done = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    ssp_sync_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .wr_en  (frame_done),
        .wr_data(wr_data),
        .rd_en  (do_read),
        .rd_data(rx_d),
        .empty  (rx_empty),
        .full   (rx_full),
        .level  (rx_level),
        .wr_drop(wr_drop)
    );

    // Sticky flags: a set event in the same cycle as ovr_clr wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      overrun <= 1'b0;
        else if (wr_drop) overrun <= 1'b1;
        else if (ovr_clr) overrun <= 1'b0;
    end

`ifdef SSP_RX_PARITY_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      parity_err <= 1'b0;
        else if (par_bad) parity_err <= 1'b1;
        else if (ovr_clr) parity_err <= 1'b0;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ssp_rx_param.sv
// Bench for ssp_rx_param: MSB-first and LSB-first instances share the serial pins.
module tb_ssp_rx_param;

    localparam int DW = 8;
    localparam int DP = 4;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic rst_ni, do_read, ovr_clr, sspclkin, sspfssin, ssprxd;
    logic [DW-1:0] m_d, l_d;
    logic [2:0]    m_level, l_level;
    logic m_empty, m_full, m_ovr, m_perr;
    logic l_empty, l_full, l_ovr, l_perr;

    ssp_rx_param #(.DATA_W(DW), .DEPTH(DP), .SYNC_STAGES(2), .MSB_FIRST(1'b1)) u_msb (
        .clk_i(clk_i), .rst_ni(rst_ni), .do_read(do_read), .ovr_clr(ovr_clr),
        .rx_d(m_d), .rx_empty(m_empty), .rx_full(m_full), .rx_level(m_level),
        .overrun(m_ovr), .parity_err(m_perr),
        .sspclkin(sspclkin), .sspfssin(sspfssin), .ssprxd(ssprxd));

    ssp_rx_param #(.DATA_W(DW), .DEPTH(DP), .SYNC_STAGES(2), .MSB_FIRST(1'b0)) u_lsb (
        .clk_i(clk_i), .rst_ni(rst_ni), .do_read(do_read), .ovr_clr(ovr_clr),
        .rx_d(l_d), .rx_empty(l_empty), .rx_full(l_full), .rx_level(l_level),
        .overrun(l_ovr), .parity_err(l_perr),
        .sspclkin(sspclkin), .sspfssin(sspfssin), .ssprxd(ssprxd));

    // Reference model: queues of expected words per bit order plus sticky flags.
    logic [DW-1:0] q_m[$];
    logic [DW-1:0] q_l[$];
    bit   mdl_ovr, mdl_perr;
    int   checks, failures;
    logic pre_empty, post_empty;

    typedef struct {
        logic [DW-1:0] w;
        logic [DW-1:0] exp_m;
        logic [DW-1:0] exp_l;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rev(input logic [DW-1:0] w);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) r[i] = w[DW-1-i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ssp_bit(input logic fss, input logic b);
        sspclkin = 1'b0;
        sspfssin = fss;
        ssprxd   = b;
        repeat (4) tick();
        sspclkin = 1'b1;
        repeat (4) tick();
    endtask

    task automatic model_frame(input logic [DW-1:0] w, input bit rd, input bit clr, input bit par_ok);
        bit did_read, full_b, set_o, set_p;
        did_read = rd && (q_m.size() > 0);
        full_b   = (q_m.size() == DP);
        set_o    = 1'b0;
        set_p    = 1'b0;
        if (did_read) begin
            void'(q_m.pop_front());
            void'(q_l.pop_front());
        end
        if (par_ok) begin
            if (full_b && !did_read) set_o = 1'b1;
            else begin
                q_m.push_back(w);
                q_l.push_back(rev(w));
            end
        end else set_p = 1'b1;
        mdl_ovr  = set_o | (mdl_ovr & ~clr);
        mdl_perr = set_p | (mdl_perr & ~clr);
    endtask

    // Sends a frame, sent MSB of w first. rd/clr pulse in the final sample-event cycle.
    task automatic send_frame(input logic [DW-1:0] w, input bit rd, input bit clr,
                              input bit bad_par, input bit rand_fss);
        logic last;
        bit   par_ok;
        ssp_bit(1'b1, 1'($urandom_range(0, 1)));
        for (int i = 0; i < DW - 1; i++)
            ssp_bit(rand_fss ? 1'($urandom_range(0, 1)) : 1'b0, w[DW-1-i]);
`ifdef SSP_RX_PARITY_EN
        ssp_bit(1'b0, w[0]);
        last   = (^w) ^ bad_par;
        par_ok = !bad_par;
`else
        last   = w[0];
        par_ok = 1'b1;
`endif
        sspclkin = 1'b0;
        sspfssin = 1'b0;
        ssprxd   = last;
        repeat (4) tick();
        sspclkin = 1'b1;
        repeat (2) tick();
        pre_empty = m_empty;
        do_read   = rd;
        ovr_clr   = clr;
        tick();
        do_read    = 1'b0;
        ovr_clr    = 1'b0;
        post_empty = m_empty;
        tick();
        model_frame(w, rd, clr, par_ok);
    endtask

    task automatic do_pop();
        do_read = 1'b1;
        tick();
        do_read = 1'b0;
        if (q_m.size() > 0) begin
            void'(q_m.pop_front());
            void'(q_l.pop_front());
        end
    endtask

    task automatic do_clr();
        ovr_clr = 1'b1;
        tick();
        ovr_clr  = 1'b0;
        mdl_ovr  = 1'b0;
        mdl_perr = 1'b0;
    endtask

    task automatic compare_all(input string tag);
        int n;
        n = q_m.size();
        chk({tag, ".m_empty"}, 32'(m_empty), 32'(n == 0));
        chk({tag, ".m_full"},  32'(m_full),  32'(n == DP));
        chk({tag, ".m_level"}, 32'(m_level), 32'(n));
        chk({tag, ".m_ovr"},   32'(m_ovr),   32'(mdl_ovr));
        chk({tag, ".m_perr"},  32'(m_perr),  32'(mdl_perr));
        chk({tag, ".l_level"}, 32'(l_level), 32'(n));
        chk({tag, ".l_ovr"},   32'(l_ovr),   32'(mdl_ovr));
        chk({tag, ".l_perr"},  32'(l_perr),  32'(mdl_perr));
        if (n > 0) begin
            chk({tag, ".m_d"}, 32'(m_d), 32'(q_m[0]));
            chk({tag, ".l_d"}, 32'(l_d), 32'(q_l[0]));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".m_d"},     32'(m_d),     32'h0);
        chk({tag, ".m_empty"}, 32'(m_empty), 32'h1);
        chk({tag, ".m_full"},  32'(m_full),  32'h0);
        chk({tag, ".m_level"}, 32'(m_level), 32'h0);
        chk({tag, ".m_ovr"},   32'(m_ovr),   32'h0);
        chk({tag, ".m_perr"},  32'(m_perr),  32'h0);
        chk({tag, ".l_empty"}, 32'(l_empty), 32'h1);
        chk({tag, ".l_d"},     32'(l_d),     32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        mdl_ovr  = 1'b0;
        mdl_perr = 1'b0;
        tbl[0] = '{w: 8'hA5, exp_m: 8'hA5, exp_l: 8'hA5};
        tbl[1] = '{w: 8'h01, exp_m: 8'h01, exp_l: 8'h80};
        tbl[2] = '{w: 8'h3C, exp_m: 8'h3C, exp_l: 8'h3C};
        tbl[3] = '{w: 8'hF0, exp_m: 8'hF0, exp_l: 8'h0F};
        tbl[4] = '{w: 8'h12, exp_m: 8'h12, exp_l: 8'h48};

        rst_ni = 1'b0; do_read = 1'b0; ovr_clr = 1'b0;
        sspclkin = 1'b0; sspfssin = 1'b0; ssprxd = 1'b0;
        repeat (3) tick();
        check_reset_vals("reset");
        rst_ni = 1'b1;
        tick();

        // Write latency of the first frame.
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lat_pre_empty",  32'(pre_empty),  32'h1);
        chk("lat_post_empty", 32'(post_empty), 32'h0);
        chk("lat_level",      32'(m_level),    32'h1);
        compare_all("lat");
        do_pop();
        compare_all("lat_pop");

        foreach (tbl[k]) begin
            send_frame(tbl[k].w, 1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("tbl%0d.m_d", k), 32'(m_d), 32'(tbl[k].exp_m));
            chk($sformatf("tbl%0d.l_d", k), 32'(l_d), 32'(tbl[k].exp_l));
            chk($sformatf("tbl%0d.lvl", k), 32'(m_level), 32'h1);
            do_pop();
            chk($sformatf("tbl%0d.empty", k), 32'(m_empty), 32'h1);
        end

        // Overrun with DEPTH+1 frames and no reads.
        for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr.full",  32'(m_full),  32'h1);
        chk("ovr.flag",  32'(m_ovr),   32'h1);
        chk("ovr.level", 32'(m_level), 32'h4);
        compare_all("ovr");
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("ovr.rd%0d", k), 32'(m_d), 32'(k));
            do_pop();
        end
        do_clr();
        chk("ovr.clr", 32'(m_ovr), 32'h0);

        // Read coinciding with the write into a full FIFO.
        for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h05, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("coin.ovr",   32'(m_ovr),   32'h0);
        chk("coin.level", 32'(m_level), 32'h4);
        for (int k = 2; k <= 5; k++) begin
            chk($sformatf("coin.rd%0d", k), 32'(m_d), 32'(k));
            do_pop();
        end
        compare_all("coin_end");

        // Overrun set coinciding with ovr_clr: set wins.
        for (int k = 0; k < 4; k++) send_frame(8'(8'h10 + k), 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h14, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("setwin.ovr", 32'(m_ovr), 32'h1);
        compare_all("setwin");
        do_clr();
        while (q_m.size() > 0) do_pop();
        compare_all("setwin_drain");

        // Reset mid-frame discards the partial frame and the FIFO contents.
        send_frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
        ssp_bit(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) ssp_bit(1'b0, 1'b1);
        rst_ni = 1'b0;
        repeat (2) tick();
        check_reset_vals("midrst");
        q_m.delete();
        q_l.delete();
        mdl_ovr  = 1'b0;
        mdl_perr = 1'b0;
        sspclkin = 1'b0;
        rst_ni   = 1'b1;
        repeat (2) tick();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst.m_d",   32'(m_d),     32'h3C);
        chk("midrst.l_d",   32'(l_d),     32'h3C);
        chk("midrst.level", 32'(m_level), 32'h1);
        do_pop();

`ifdef SSP_RX_PARITY_EN
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("par_ok.level", 32'(m_level), 32'h1);
        chk("par_ok.perr",  32'(m_perr),  32'h0);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("par_bad.level", 32'(m_level), 32'h1);
        chk("par_bad.perr",  32'(m_perr),  32'h1);
        chk("par_bad.ovr",   32'(m_ovr),   32'h0);
        do_clr();
        chk("par_clr.perr", 32'(m_perr), 32'h0);
        do_pop();
`endif
        compare_all("pre_rand");

        for (int it = 0; it < 40; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5)
                send_frame(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                           $urandom_range(0, 4) == 0, 1'b1);
            else if (r < 8) do_pop();
            else            do_clr();
            compare_all($sformatf("rand%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
